// File: rtl/scrambler_stream.sv
// scrambler_stream
//   Self-synchronous scrambler/descrambler, polynomial x^LFSR_W + x^TAP + 1.
//   Each accepted beat is processed bit 0 first, and the result is registered.
//   A valid/ready handshake carries beats in and out. The block also supports
//   a run-time scramble/descramble mode, a bypass path and a seed load.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   i_mode               0 = scramble, 1 = descramble (sampled per accepted beat)
//   i_bypass             pass beat unchanged, LFSR held (sampled per accepted beat)
//   i_seed_load          load i_seed_val into the LFSR when o_in_ready = 1
//   i_seed_val           seed value
//   i_in_valid           input beat valid
//   o_in_ready           input beat can be accepted
//   i_in_data            input beat, bit 0 transmitted first
//   o_out_valid          output beat valid
//   i_out_ready          downstream accepts output beat
//   o_out_data           processed beat
//   o_lfsr_state         current LFSR contents (debug)
//   o_beat_cnt           accepted non-bypass beats (only with SCR_BEAT_CNT_EN)
//
// Optional feature macro: SCR_BEAT_CNT_EN
module scrambler_stream #(
   parameter int unsigned       DATA_W   = 257,
   parameter int unsigned       LFSR_W   = 58,
   parameter int unsigned       TAP      = 39,
   parameter logic [LFSR_W-1:0] SEED_RST = '1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_mode,
   input  logic              i_bypass,
   input  logic              i_seed_load,
   input  logic [LFSR_W-1:0] i_seed_val,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
`ifdef SCR_BEAT_CNT_EN
   output logic [31:0]       o_beat_cnt,
`endif
   output logic [LFSR_W-1:0] o_lfsr_state
);

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic [LFSR_W-1:0] r_lfsr;

   logic              w_in_ready;
   logic              w_accept;
   logic              w_seed_eff;
   logic [LFSR_W-1:0] w_start;
   logic [LFSR_W-1:0] w_s;
   logic [DATA_W-1:0] w_o;
   logic [LFSR_W-1:0] w_lfsr_d;

   assign w_in_ready = !r_out_valid || i_out_ready;
   assign w_accept   = i_in_valid && w_in_ready;
   assign w_seed_eff = i_seed_load && w_in_ready;
   // A seed loaded alongside an accepted beat is the starting state for that beat.
   assign w_start    = w_seed_eff ? i_seed_val : r_lfsr;

   // Bit-serial recurrence unrolled across the beat. In scramble mode the
   // feedback is the scrambled bit. In descramble mode it is the received bit.
   always_comb begin
      w_s = w_start;
      w_o = '0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         w_o[i] = i_in_data[i] ^ w_s[LFSR_W-1] ^ w_s[TAP-1];
         w_s    = {w_s[LFSR_W-2:0], (i_mode ? i_in_data[i] : w_o[i])};
      end
   end

   always_comb begin
      w_lfsr_d = r_lfsr;
      if (w_seed_eff) w_lfsr_d = i_seed_val;
      if (w_accept && !i_bypass) w_lfsr_d = w_s;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lfsr      <= SEED_RST;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_lfsr <= w_lfsr_d;
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= i_bypass ? i_in_data : w_o;
         end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

`ifdef SCR_BEAT_CNT_EN
   logic [31:0] r_beat_cnt;

   // A seed load clears the count. A beat accepted in the same cycle is the first one counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_beat_cnt <= '0;
      end else if (w_seed_eff) begin
         r_beat_cnt <= (w_accept && !i_bypass) ? 32'd1 : 32'd0;
      end else if (w_accept && !i_bypass) begin
         r_beat_cnt <= r_beat_cnt + 32'd1;
      end
   end

   assign o_beat_cnt = r_beat_cnt;
`endif

   assign o_in_ready   = w_in_ready;
   assign o_out_valid  = r_out_valid;
   assign o_out_data   = r_out_data;
   assign o_lfsr_state = r_lfsr;

endmodule

// File: tb/tb_scrambler_stream.sv
module tb_scrambler_stream;
   localparam int DW = 257;
   localparam int LW = 58;
   localparam int TP = 39;
   localparam logic [LW-1:0] SEED = '1;

   logic          clk = 1'b0;
   logic          rst;
   logic          mode, bypass, seed_load, in_valid, tb_ready;
   logic [LW-1:0] seed_val;
   logic [DW-1:0] in_data;
   logic          scr_in_ready, scr_out_valid, scr_out_ready;
   logic [DW-1:0] scr_out_data;
   logic [LW-1:0] scr_lfsr;
   logic          des_seed_load, des_in_valid, des_in_ready, des_out_valid;
   logic [LW-1:0] des_seed_val, des_lfsr;
   logic [DW-1:0] des_out_data;
`ifdef SCR_BEAT_CNT_EN
   logic [31:0]   scr_cnt, des_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state
   logic          m_vld, d_vld;
   logic [DW-1:0] m_data, d_data;
   logic [LW-1:0] m_lfsr, d_lfsr;
   logic [31:0]   m_cnt;
   logic [DW-1:0] orig_q[$];

   always #5 clk = ~clk;

   // Descrambler is fed from the scrambler; tb_ready gates the link.
   assign scr_out_ready = tb_ready && des_in_ready;
   assign des_in_valid  = scr_out_valid && tb_ready;

   scrambler_stream u_scr (
      .clk         (clk),
      .rst         (rst),
      .i_mode      (mode),
      .i_bypass    (bypass),
      .i_seed_load (seed_load),
      .i_seed_val  (seed_val),
      .i_in_valid  (in_valid),
      .o_in_ready  (scr_in_ready),
      .i_in_data   (in_data),
      .o_out_valid (scr_out_valid),
      .i_out_ready (scr_out_ready),
      .o_out_data  (scr_out_data),
`ifdef SCR_BEAT_CNT_EN
      .o_beat_cnt  (scr_cnt),
`endif
      .o_lfsr_state(scr_lfsr)
   );

   scrambler_stream u_des (
      .clk         (clk),
      .rst         (rst),
      .i_mode      (1'b1),
      .i_bypass    (1'b0),
      .i_seed_load (des_seed_load),
      .i_seed_val  (des_seed_val),
      .i_in_valid  (des_in_valid),
      .o_in_ready  (des_in_ready),
      .i_in_data   (scr_out_data),
      .o_out_valid (des_out_valid),
      .i_out_ready (1'b1),
      .o_out_data  (des_out_data),
`ifdef SCR_BEAT_CNT_EN
      .o_beat_cnt  (des_cnt),
`endif
      .o_lfsr_state(des_lfsr)
   );

   // Line-bit history model: out = in ^ line[LW ago] ^ line[TP ago], where
   // "line" is the scrambled stream (the one both ends see).
   function automatic void model_beat(input logic [LW-1:0] st, input logic [DW-1:0] d,
                                      input logic md, output logic [DW-1:0] o,
                                      output logic [LW-1:0] st_n);
      logic h [0:LW+DW-1];
      for (int j = 0; j < LW; j++) h[LW-1-j] = st[j];
      for (int i = 0; i < DW; i++) begin
         o[i]    = d[i] ^ h[i] ^ h[LW+i-TP];
         h[LW+i] = md ? d[i] : o[i];
      end
      for (int j = 0; j < LW; j++) st_n[j] = h[LW+DW-1-j];
   endfunction

   function automatic logic [DW-1:0] rand_beat();
      logic [287:0] t;
      for (int k = 0; k < 9; k++) t[k*32 +: 32] = $urandom();
      return t[DW-1:0];
   endfunction

   task automatic model_reset();
      m_vld = 1'b0; m_data = '0; m_lfsr = SEED; m_cnt = '0;
      d_vld = 1'b0; d_data = '0; d_lfsr = SEED;
      orig_q.delete();
   endtask

   task automatic idle_inputs();
      mode = 1'b0; bypass = 1'b0; seed_load = 1'b0; seed_val = '0; in_valid = 1'b0;
      in_data = '0; tb_ready = 1'b1; des_seed_load = 1'b0; des_seed_val = '0;
   endtask

   // Advance the reference by one clock with the inputs currently driven,
   // then move to the next falling edge.
   task automatic tick(input bit push_orig);
      logic          acc, rdy;
      logic [DW-1:0] o;
      logic [LW-1:0] st, s;
      st = des_seed_load ? des_seed_val : d_lfsr;
      if (m_vld && tb_ready) begin
         model_beat(st, m_data, 1'b1, o, s);
         d_data = o; d_lfsr = s; d_vld = 1'b1;
      end else begin
         d_lfsr = st; d_vld = 1'b0;
      end
      rdy = !m_vld || tb_ready;
      acc = in_valid && rdy;
      st  = (seed_load && rdy) ? seed_val : m_lfsr;
      if (seed_load && rdy) m_cnt = (acc && !bypass) ? 32'd1 : 32'd0;
      else if (acc && !bypass) m_cnt = m_cnt + 32'd1;
      if (acc) begin
         if (bypass) begin
            m_data = in_data; m_lfsr = st;
         end else begin
            model_beat(st, in_data, mode, o, s);
            m_data = o; m_lfsr = s;
            if (push_orig) orig_q.push_back(in_data);
         end
         m_vld = 1'b1;
      end else begin
         m_lfsr = st;
         if (tb_ready) m_vld = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if (scr_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", scr_out_valid); end
      n_checks++;
      if (scr_out_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", scr_out_data); end
      n_checks++;
      if (scr_lfsr !== SEED) begin n_fail++; $display("FAIL reset_lfsr got=%h exp=%h", scr_lfsr, SEED); end
`ifdef SCR_BEAT_CNT_EN
      n_checks++;
      if (scr_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", scr_cnt); end
`endif
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      n_checks++;
      if (scr_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", scr_in_ready); end
      n_checks++;
      if (scr_lfsr !== SEED) begin n_fail++; $display("FAIL reset_idle_lfsr got=%h exp=%h", scr_lfsr, SEED); end
   endtask

   task automatic test_first_beat();
      logic [39:0] low;
      do_reset();
      in_valid = 1'b1; in_data = '0; mode = 1'b0;
      #1;
      n_checks++;
      if (scr_in_ready !== 1'b1) begin n_fail++; $display("FAIL first_in_ready got=%b exp=1", scr_in_ready); end
      tick(1'b0);
      in_valid = 1'b0;
      low = scr_out_data[39:0];
      n_checks++;
      if (scr_out_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got=%b exp=1", scr_out_valid); end
      n_checks++;
      if (low !== 40'h80_0000_0000) begin n_fail++; $display("FAIL first_low_bits got=%h exp=8000000000", low); end
      n_checks++;
      if (scr_out_data !== m_data) begin n_fail++; $display("FAIL first_data got=%h exp=%h", scr_out_data, m_data); end
      n_checks++;
      if (scr_lfsr !== m_lfsr) begin n_fail++; $display("FAIL first_lfsr got=%h exp=%h", scr_lfsr, m_lfsr); end
      tick(1'b0);
      n_checks++;
      if (scr_out_valid !== 1'b0) begin n_fail++; $display("FAIL first_valid_drop got=%b exp=0", scr_out_valid); end
      n_checks++;
      if (scr_lfsr !== m_lfsr) begin n_fail++; $display("FAIL first_idle_lfsr got=%h exp=%h", scr_lfsr, m_lfsr); end
   endtask

   task automatic test_loopback();
      int sent = 0, got = 0, cyc = 0;
      logic [DW-1:0] exp;
      do_reset();
      while ((sent < 1000 || got < sent) && cyc < 6000) begin
         cyc++;
         in_valid = (sent < 1000) && ($urandom_range(0, 7) != 0);
         in_data  = rand_beat();
         tb_ready = ($urandom_range(0, 5) != 0);
         #1;
         n_checks++;
         if (scr_in_ready !== (!m_vld || tb_ready)) begin
            n_fail++; $display("FAIL loop_in_ready got=%b exp=%b", scr_in_ready, !m_vld || tb_ready);
         end
         if (in_valid && (!m_vld || tb_ready)) sent++;
         tick(1'b1);
         n_checks++;
         if (scr_out_valid !== m_vld || scr_out_data !== m_data || scr_lfsr !== m_lfsr) begin
            n_fail++;
            $display("FAIL loop_scr got=%b/%h exp=%b/%h", scr_out_valid, scr_lfsr, m_vld, m_lfsr);
         end
         n_checks++;
         if (des_out_valid !== d_vld) begin n_fail++; $display("FAIL loop_des_valid got=%b exp=%b", des_out_valid, d_vld); end
         if (d_vld) begin
            exp = orig_q.pop_front();
            got++;
            n_checks++;
            if (des_out_data !== exp) begin n_fail++; $display("FAIL loop_des_data got=%h exp=%h", des_out_data, exp); end
         end
      end
      in_valid = 1'b0; tb_ready = 1'b1;
      n_checks++;
      if (got != 1000) begin n_fail++; $display("FAIL loop_count got=%0d exp=1000", got); end
   endtask

   task automatic test_self_sync();
      int got = 0;
      logic [DW-1:0] exp;
      do_reset();
      des_seed_load = 1'b1; des_seed_val = '0;
      tick(1'b0);
      des_seed_load = 1'b0;
      n_checks++;
      if (des_lfsr !== '0) begin n_fail++; $display("FAIL sync_seed got=%h exp=0", des_lfsr); end
      for (int c = 0; c < 24; c++) begin
         in_valid = (c < 20); in_data = rand_beat();
         tick(1'b1);
         n_checks++;
         if (des_out_valid !== d_vld || des_out_data !== d_data) begin
            n_fail++; $display("FAIL sync_des_model got=%b/%h exp=%b/%h", des_out_valid, des_out_data, d_vld, d_data);
         end
         if (d_vld) begin
            exp = orig_q.pop_front();
            got++;
            if (got > 1) begin
               n_checks++;
               if (des_out_data !== exp) begin n_fail++; $display("FAIL sync_data beat=%0d got=%h exp=%h", got, des_out_data, exp); end
            end
         end
      end
      n_checks++;
      if (got != 20) begin n_fail++; $display("FAIL sync_count got=%0d exp=20", got); end
   endtask

   task automatic test_backpressure();
      int got = 0;
      logic [DW-1:0] hold_data, exp;
      logic [LW-1:0] hold_lfsr;
      do_reset();
      in_valid = 1'b1; in_data = rand_beat();
      tick(1'b1);
      tb_ready = 1'b0; in_data = rand_beat();
      hold_data = m_data; hold_lfsr = m_lfsr;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_checks++;
         if (scr_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", scr_in_ready); end
         tick(1'b1);
         n_checks++;
         if (scr_out_valid !== 1'b1 || scr_out_data !== hold_data || scr_lfsr !== hold_lfsr) begin
            n_fail++; $display("FAIL bp_hold got=%b/%h exp=1/%h", scr_out_valid, scr_lfsr, hold_lfsr);
         end
      end
      tb_ready = 1'b1;
      #1;
      n_checks++;
      if (scr_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got=%b exp=1", scr_in_ready); end
      for (int c = 0; c < 4; c++) begin
         tick(1'b1);
         in_valid = 1'b0;
         n_checks++;
         if (scr_out_valid !== m_vld || scr_out_data !== m_data || scr_lfsr !== m_lfsr) begin
            n_fail++; $display("FAIL bp_after got=%b/%h exp=%b/%h", scr_out_valid, scr_lfsr, m_vld, m_lfsr);
         end
         if (d_vld) begin
            exp = orig_q.pop_front();
            got++;
            n_checks++;
            if (des_out_data !== exp) begin n_fail++; $display("FAIL bp_des_data got=%h exp=%h", des_out_data, exp); end
         end
      end
      n_checks++;
      if (got != 2) begin n_fail++; $display("FAIL bp_count got=%0d exp=2", got); end
   endtask

   task automatic test_seed_bypass();
      logic [DW-1:0] byp;
      byp = {{(DW-9){1'b0}}, 9'h1A5};
      do_reset();
      seed_load = 1'b1; seed_val = '0; in_valid = 1'b1; in_data = '0; mode = 1'b0;
      tick(1'b0);
      seed_load = 1'b0;
      n_checks++;
      if (scr_out_data !== '0 || scr_lfsr !== '0) begin
         n_fail++; $display("FAIL seed_zero got=%h/%h exp=0/0", scr_out_data, scr_lfsr);
      end
`ifdef SCR_BEAT_CNT_EN
      n_checks++;
      if (scr_cnt !== 32'd1) begin n_fail++; $display("FAIL seed_cnt got=%0d exp=1", scr_cnt); end
`endif
      bypass = 1'b1; in_data = byp;
      tick(1'b0);
      bypass = 1'b0; in_valid = 1'b0;
      n_checks++;
      if (scr_out_data !== byp || scr_lfsr !== '0 || scr_out_valid !== 1'b1) begin
         n_fail++; $display("FAIL bypass got=%h/%h exp=%h/0", scr_out_data, scr_lfsr, byp);
      end
`ifdef SCR_BEAT_CNT_EN
      n_checks++;
      if (scr_cnt !== 32'd1) begin n_fail++; $display("FAIL bypass_cnt got=%0d exp=1", scr_cnt); end
`endif
      // Seed load while stalled must be ignored.
      tb_ready = 1'b0; seed_load = 1'b1; seed_val = 58'h2AB_CDEF_0123_4567;
      tick(1'b0);
      seed_load = 1'b0;
      n_checks++;
      if (scr_lfsr !== '0) begin n_fail++; $display("FAIL seed_ignored got=%h exp=0", scr_lfsr); end
      tb_ready = 1'b1;
      tick(1'b0);
   endtask

   task automatic test_random_modes();
      do_reset();
      for (int c = 0; c < 300; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = rand_beat();
         mode      = 1'($urandom_range(0, 1));
         bypass    = ($urandom_range(0, 5) == 0);
         seed_load = ($urandom_range(0, 9) == 0);
         seed_val  = {$urandom(), $urandom()};
         tb_ready  = ($urandom_range(0, 3) != 0);
         #1;
         n_checks++;
         if (scr_in_ready !== (!m_vld || tb_ready)) begin
            n_fail++; $display("FAIL rnd_in_ready got=%b exp=%b", scr_in_ready, !m_vld || tb_ready);
         end
         tick(1'b0);
         n_checks++;
         if (scr_out_valid !== m_vld || scr_out_data !== m_data || scr_lfsr !== m_lfsr) begin
            n_fail++; $display("FAIL rnd_scr cyc=%0d got=%b/%h exp=%b/%h", c, scr_out_valid, scr_lfsr, m_vld, m_lfsr);
         end
`ifdef SCR_BEAT_CNT_EN
         n_checks++;
         if (scr_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt got=%0d exp=%0d", scr_cnt, m_cnt); end
`endif
      end
      idle_inputs();
   endtask

   task automatic test_reset_midstream();
      do_reset();
      in_valid = 1'b1; in_data = rand_beat();
      tick(1'b0);
      in_valid = 1'b0; tb_ready = 1'b0;
      tick(1'b0);
      n_checks++;
      if (scr_out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got=%b exp=1", scr_out_valid); end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (scr_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got=%b exp=0", scr_out_valid); end
      n_checks++;
      if (scr_lfsr !== SEED) begin n_fail++; $display("FAIL mid_lfsr got=%h exp=%h", scr_lfsr, SEED); end
`ifdef SCR_BEAT_CNT_EN
      n_checks++;
      if (scr_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_cnt got=%0d exp=0", scr_cnt); end
`endif
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      idle_inputs();
      tick(1'b0);
   endtask

   initial begin
      test_reset();
      test_first_beat();
      test_loopback();
      test_self_sync();
      test_backpressure();
      test_seed_bypass();
      test_random_modes();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
